// File: rtl/tx_pulse_gen.sv
// rtl/tx_pulse_gen.sv - per-channel delayed bipolar transmit burst generator (optional TX_MASK_EN channel mask)
module tx_pulse_gen #(
    parameter int NUM_CHANNELS      = 4,
    parameter int DELAY_WIDTH       = 8,
    parameter int HALF_PERIOD_WIDTH = 8,
    parameter int NUM_CYCLES_WIDTH  = 4,
    parameter int TIME_WIDTH        = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [NUM_CHANNELS*DELAY_WIDTH-1:0] delay_flat,
    input  logic [HALF_PERIOD_WIDTH-1:0]        half_period,
    input  logic [NUM_CYCLES_WIDTH-1:0]         num_cycles,
`ifdef TX_MASK_EN
    input  logic [NUM_CHANNELS-1:0]             ch_mask,
`endif
    output logic [NUM_CHANNELS-1:0]             tx_p,
    output logic [NUM_CHANNELS-1:0]             tx_n,
    output logic                                busy,
    output logic                                done,
    output logic [1:0]                          debug_state
);

    localparam int BURST_W = HALF_PERIOD_WIDTH + NUM_CYCLES_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state, next_state;
    logic [TIME_WIDTH-1:0]        t;
    logic [DELAY_WIDTH-1:0]       lat_delay [NUM_CHANNELS];
    logic [HALF_PERIOD_WIDTH-1:0] lat_hp;
    logic [BURST_W-1:0]           lat_burst;
    logic [NUM_CHANNELS-1:0]      run, fin, neg, fin_next, start_mask;
    logic [HALF_PERIOD_WIDTH-1:0] ph_cnt [NUM_CHANNELS];
    logic [BURST_W-1:0]           cnt    [NUM_CHANNELS];
    logic [BURST_W-1:0]           burst_len;
    logic                         empty_event;

    // Channel enables for a new event; the mask is packed like delay_flat (channel 0 in the MSB).
    always_comb begin
        start_mask = '1;
`ifdef TX_MASK_EN
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            start_mask[i] = ch_mask[NUM_CHANNELS-1-i];
        end
`endif
    end

    // Burst length and the "nothing to fire" condition for the event being started.
    always_comb begin
        burst_len   = (BURST_W'(half_period) * BURST_W'(num_cycles)) << 1;
        empty_event = (half_period == '0) || (num_cycles == '0) || (start_mask == '0);
    end

    // Finished flags as they will be after this edge, and FSM next state.
    always_comb begin
        next_state = state;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            fin_next[i] = fin[i] | (run[i] && (cnt[i] == lat_burst));
        end
        case (state)
            IDLE:    if (start) next_state = empty_event ? DONE : FIRE;
            FIRE:    if (&fin_next) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Latch settings on an accepted start and run the global firing timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            t         <= '0;
            lat_hp    <= '0;
            lat_burst <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) lat_delay[i] <= '0;
        end else if (state == IDLE) begin
            t <= '0;
            if (start) begin
                lat_hp    <= half_period;
                lat_burst <= burst_len;
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    lat_delay[i] <= delay_flat[(NUM_CHANNELS-1-i)*DELAY_WIDTH +: DELAY_WIDTH];
                end
            end
        end else if (state == FIRE) begin
            t <= t + 1'b1;
        end else begin
            t <= '0;
        end
    end

    // Per-channel burst engines: arm when t hits the delay, then emit p/n phases and drop low.
    always_ff @(posedge clk) begin
        if (reset || (state != IDLE && state != FIRE)) begin
            tx_p <= '0;
            tx_n <= '0;
            run  <= '0;
            fin  <= '0;
            neg  <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                ph_cnt[i] <= '0;
                cnt[i]    <= '0;
            end
        end else if (state == IDLE) begin
            tx_p <= '0;
            tx_n <= '0;
            run  <= '0;
            neg  <= '0;
            fin  <= start ? ~start_mask : '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                ph_cnt[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (run[i]) begin
                    if (cnt[i] == lat_burst) begin
                        tx_p[i] <= 1'b0;
                        tx_n[i] <= 1'b0;
                        run[i]  <= 1'b0;
                        fin[i]  <= 1'b1;
                    end else begin
                        tx_p[i] <= ~neg[i];
                        tx_n[i] <= neg[i];
                        cnt[i]  <= cnt[i] + 1'b1;
                        if (ph_cnt[i] == lat_hp - HALF_PERIOD_WIDTH'(1)) begin
                            ph_cnt[i] <= '0;
                            neg[i]    <= ~neg[i];
                        end else begin
                            ph_cnt[i] <= ph_cnt[i] + 1'b1;
                        end
                    end
                end else if (!fin[i] && (t == TIME_WIDTH'(lat_delay[i]))) begin
                    run[i]    <= 1'b1;
                    cnt[i]    <= '0;
                    ph_cnt[i] <= '0;
                    neg[i]    <= 1'b0;
                end
            end
        end
    end

    assign busy        = (state == FIRE) || (state == DONE);
    assign done        = (state == DONE);
    assign debug_state = state;

endmodule

// File: doc/tx_pulse_gen.md
Name: tx_pulse_gen

Overview:
- Transmit-side counterpart of the receive beamformer. Fires per-channel bipolar excitation bursts into the transducer front end, each channel offset by its own focusing delay, so the transmit wavefront focuses where the receive path later sums.
- Delays are supplied precomputed as a flat vector, in the same channel packing the receive delay controller uses.
- A simple FSM sequences idle, firing and done, and reports completion to the acquisition controller.

Parameters:
- NUM_CHANNELS, 4, number of transmit channels.
- DELAY_WIDTH, 8, width of each per-channel delay, in clk cycles.
- HALF_PERIOD_WIDTH, 8, width of the half-period setting.
- NUM_CYCLES_WIDTH, 4, width of the burst-cycle-count setting.
- TIME_WIDTH, 16, width of the global firing timer. Must satisfy 2^TIME_WIDTH > (2^DELAY_WIDTH-1) + 2*(2^HALF_PERIOD_WIDTH-1)*(2^NUM_CYCLES_WIDTH-1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin one transmit event; sampled only in IDLE
- delay_flat  input  NUM_CHANNELS*DELAY_WIDTH  per-channel delays; channel 0 occupies the MSB slice and channel NUM_CHANNELS-1 the LSB slice
- half_period  input  HALF_PERIOD_WIDTH  clk cycles per pulse phase
- num_cycles  input  NUM_CYCLES_WIDTH  full p/n cycles per burst
- tx_p  output  NUM_CHANNELS  positive-drive enable per channel
- tx_n  output  NUM_CHANNELS  negative-drive enable per channel
- busy  output  1  high in FIRE and DONE
- done  output  1  one-cycle completion pulse
- debug_state  output  2  current FSM state encoding

Behaviour:
- Reset applies at the next rising clk edge. After it:
  - state = IDLE
  - tx_p = 0, tx_n = 0, busy = 0, done = 0
  - timer and all per-channel counters = 0
- Reset asserted mid-burst forces all of the above at the next edge. No partial pulse remains.
- State encoding: IDLE = 0, FIRE = 1, DONE = 2. Code 3 is unused and recovers to IDLE on the next edge.
- IDLE:
  - On the edge where start = 1, latch delay_flat, half_period and num_cycles, and clear the timer t to 0.
  - If half_period == 0 or num_cycles == 0, go to DONE and fire no pulses.
  - Otherwise go to FIRE.
- FIRE:
  - t increments by 1 every cycle.
  - A channel enters its burst on the edge where t == delay_i.
  - Burst pattern per channel: tx_p high for half_period cycles, then tx_n high for half_period cycles, repeated num_cycles times.
  - Total burst length per channel = 2*half_period*num_cycles cycles.
  - When the burst ends, the channel drives low and is flagged finished.
  - When every channel is finished, go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. busy drops on the same edge.
- Latency:
  - A delay-0 channel's tx_p rises on the 2nd rising edge after the edge that sampled start.
  - A channel with delay d rises d cycles after that.
- Channels with equal delays pulse identically and simultaneously.
- Outputs are registered. For every channel, tx_p[i] & tx_n[i] == 0 on every cycle.
- Phase change p→n occurs in a single cycle, with no idle gap.
- start while busy is ignored. Latched settings are unaffected by input changes during FIRE.
- Timer does not wrap; the parameter constraint guarantees this.

Optional Feature:
- Macro: TX_MASK_EN.
- When defined:
  - Adds input ch_mask, width NUM_CHANNELS, latched with start.
  - A channel with ch_mask[i] = 0 keeps tx_p/tx_n low and is treated as finished immediately.
  - If all mask bits are 0, the FSM goes IDLE→DONE directly.
- When undefined: no port is added, and all channels always fire.

Test Plan:
- Delays {0,1,2,3}, half_period = 2, num_cycles = 1:
  - ch0 tx_p high on edges 2-3 after start, tx_n high on edges 4-5.
  - ch3 pattern is shifted by 3 cycles.
  - done pulses once after ch3 finishes; busy spans FIRE through DONE.
- Delays all 5, half_period = 1, num_cycles = 3: all channels toggle p,n,p,n,p,n in lockstep starting 7 cycles after start; tx_p & tx_n never both high.
- half_period = 0, or num_cycles = 0: no pulses; done high 1 cycle after start sampled; return to IDLE.
- start reasserted and delay_flat changed during FIRE: no restart, and the burst uses the originally latched delays.
- Reset asserted mid-burst: all outputs 0 and state IDLE after one edge; a fresh start afterwards behaves as the first scenario.
- TX_MASK_EN with ch_mask = 4'b1010: only ch0 and ch2 pulse. With ch_mask = 0: done follows start with no pulses.
